// File: rtl/regfile_dump_reader_if.sv
// Beat stream carrying register values (and the optional checksum) from the
// dump reader to a debug/trace sink. The reader drives it through the master
// modport and the sink receives it through the slave modport.
interface regfile_dump_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] index;
    logic              last;
    logic              is_csum;

    modport master (
        output valid,
        output data,
        output index,
        output last,
        output is_csum,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  index,
        input  last,
        input  is_csum,
        output ready
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Register file dump reader. On a start pulse it walks a spare read port of
// the integer register file through x0..x(NUM_REGS-1) and streams each value
// out as one valid/ready beat (LOAD captures, SEND holds until accepted).
// Optional feature: define REGFILE_DUMP_CHECKSUM_EN to append a final beat
// carrying the mod-2^DATA_W sum of all streamed values.
module regfile_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    output logic [ADDR_W-1:0]      rf_addr,
    input  logic [DATA_W-1:0]      rf_data,
    regfile_dump_reader_if.master  out,
    output logic                   busy,
    output logic                   done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

`ifdef REGFILE_DUMP_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, LOAD, SEND, CSUM} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
`endif

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] index_reg, index_next;
    logic [ADDR_W-1:0] beat_index_reg, beat_index_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic              last_reg, last_next;
    logic              done_reg, done_next;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum_reg, csum_next;
    logic              is_csum_reg, is_csum_next;
`endif

    // Next-state and datapath: the beat registers only change in LOAD or on
    // the final SEND handshake, so the beat stays frozen while stalled.
    always_comb begin
        state_next      = state_reg;
        index_next      = index_reg;
        beat_index_next = beat_index_reg;
        data_next       = data_reg;
        last_next       = last_reg;
        done_next       = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        csum_next       = csum_reg;
        is_csum_next    = is_csum_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    index_next = '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    csum_next  = '0;
`endif
                    state_next = LOAD;
                end
            end
            LOAD: begin
                data_next       = rf_data;
                beat_index_next = index_reg;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                // The checksum beat is the final one, never a register beat.
                last_next       = 1'b0;
                is_csum_next    = 1'b0;
                csum_next       = csum_reg + rf_data;
`else
                last_next       = (index_reg == LAST_IDX);
`endif
                state_next      = SEND;
            end
            SEND: begin
                if (out.ready) begin
                    if (index_reg == LAST_IDX) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        data_next       = csum_reg;
                        beat_index_next = '0;
                        last_next       = 1'b1;
                        is_csum_next    = 1'b1;
                        state_next      = CSUM;
`else
                        done_next       = 1'b1;
                        state_next      = IDLE;
`endif
                    end else begin
                        index_next = index_reg + ADDR_W'(1);
                        state_next = LOAD;
                    end
                end
            end
`ifdef REGFILE_DUMP_CHECKSUM_EN
            CSUM: begin
                if (out.ready) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any dump in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            index_reg      <= '0;
            beat_index_reg <= '0;
            data_reg       <= '0;
            last_reg       <= 1'b0;
            done_reg       <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum_reg       <= '0;
            is_csum_reg    <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            index_reg      <= index_next;
            beat_index_reg <= beat_index_next;
            data_reg       <= data_next;
            last_reg       <= last_next;
            done_reg       <= done_next;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum_reg       <= csum_next;
            is_csum_reg    <= is_csum_next;
`endif
        end
    end

    // The read address simply follows the walk index; it is only consumed
    // in LOAD but holding it elsewhere keeps the port quiet.
    assign rf_addr   = index_reg;
    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign out.data  = data_reg;
    assign out.index = beat_index_reg;
    assign out.last  = last_reg;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    assign out.valid   = (state_reg == SEND) || (state_reg == CSUM);
    assign out.is_csum = is_csum_reg;
`else
    assign out.valid   = (state_reg == SEND);
    assign out.is_csum = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: a register file model answers
// the read port, expected beats are queued when each dump is started and
// compared as the sink accepts beats.
module tb_regfile_dump_reader;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] index;
        logic              last;
        logic              is_csum;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rf_mem [NUM_REGS];

    beat_t exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    beats_seen = 0;

    regfile_dump_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    regfile_dump_reader #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .rf_addr (rf_addr),
        .rf_data (rf_data),
        .out     (bus),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    assign rf_data = rf_mem[rf_addr];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Queue the beats a dump should produce from the current register file,
    // optionally with x20 overwritten before the reader reaches it.
    task automatic push_dump(input bit with_write);
        logic [DATA_W-1:0] sum;
        logic [DATA_W-1:0] v;
        beat_t b;
        sum = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            v = (with_write && i == 20) ? 32'hDEADBEEF : rf_mem[i];
            sum = sum + v;
            b.data    = v;
            b.index   = ADDR_W'(i);
            b.last    = (i == NUM_REGS - 1) && !CSUM_ON;
            b.is_csum = 1'b0;
            exp_q.push_back(b);
        end
        if (CSUM_ON) begin
            b.data    = sum;
            b.index   = '0;
            b.last    = 1'b1;
            b.is_csum = 1'b1;
            exp_q.push_back(b);
        end
    endtask

    // Sink-side monitor, sampled on the falling edge.
    logic  stall_prev = 1'b0;
    logic  last_hs_prev = 1'b0;
    beat_t prev;
    always @(negedge clk) begin
        if (!reset_n) begin
            stall_prev   = 1'b0;
            last_hs_prev = 1'b0;
        end else begin
            check_value("done_pulse", done, last_hs_prev);
            if (done) check_value("busy_in_done", busy, 0);
            if (stall_prev) begin
                check_value("stall_valid", bus.valid, 1);
                check_value("stall_data", bus.data, prev.data);
                check_value("stall_index", bus.index, prev.index);
                check_value("stall_last", bus.last, prev.last);
                check_value("stall_is_csum", bus.is_csum, prev.is_csum);
            end
            if (bus.valid && bus.ready) begin
                beats_seen++;
                $display("beat idx=%0d data=0x%08h last=%0b csum=%0b",
                         bus.index, bus.data, bus.last, bus.is_csum);
                if (exp_q.size() > 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check_value("beat_data", bus.data, e.data);
                    check_value("beat_index", bus.index, e.index);
                    check_value("beat_last", bus.last, e.last);
                    check_value("beat_is_csum", bus.is_csum, e.is_csum);
                end
            end
            last_hs_prev = bus.valid && bus.ready && bus.last;
            stall_prev   = bus.valid && !bus.ready;
            prev.data    = bus.data;
            prev.index   = bus.index;
            prev.last    = bus.last;
            prev.is_csum = bus.is_csum;
        end
    end

    // Run one dump. Mode: 0 ready held, 1 backpressure, 2 start while busy,
    // 3 reset at index 12, 4 concurrent write of x20 at index 10.
    // Entered and left 1 time unit after a rising edge.
    task automatic run_dump(input int mode);
        int cyc;
        int exp_n;
        int hold_cnt;
        bit hold_done;
        bit start_done;
        bit wr_done;
        hold_cnt = 0;
        hold_done = 1'b0;
        start_done = 1'b0;
        wr_done = 1'b0;
        push_dump(mode == 4);
        exp_n = exp_q.size();
        beats_seen = 0;
        bus.ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_value("load_busy", busy, 1);
        check_value("load_valid", bus.valid, 0);
        check_value("load_rf_addr", rf_addr, 0);
        @(posedge clk); #1;
        check_value("first_valid", bus.valid, 1);
        cyc = 0;
        while (!done && cyc < 2000) begin
            if (mode == 1) begin
                if (bus.valid && bus.index == 5 && !bus.is_csum && !hold_done) begin
                    hold_cnt = 10;
                    hold_done = 1'b1;
                end
                if (hold_cnt > 0) begin
                    bus.ready = 1'b0;
                    hold_cnt--;
                end else begin
                    bus.ready = 1'($urandom_range(0, 1));
                end
            end
            if (mode == 2 && !start_done && bus.valid && bus.index == 7) begin
                start = 1'b1;
                start_done = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (mode == 4 && !wr_done && bus.valid && bus.index == 10) begin
                rf_mem[20] = 32'hDEADBEEF;
                wr_done = 1'b1;
            end
            if (mode == 3 && bus.valid && bus.index == 12) begin
                reset_n = 1'b0;
                #1;
                check_value("rst_valid", bus.valid, 0);
                check_value("rst_busy", busy, 0);
                check_value("rst_done", done, 0);
                check_value("rst_rf_addr", rf_addr, 0);
                check_value("rst_data", bus.data, 0);
                check_value("rst_index", bus.index, 0);
                check_value("rst_last", bus.last, 0);
                exp_q.delete();
                @(posedge clk); #1;
                reset_n = 1'b1;
                @(posedge clk); #1;
                check_value("post_rst_busy", busy, 0);
                return;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check_value("done_seen", done, 1);
        check_value("beat_count", beats_seen, exp_n);
        check_value("queue_empty", exp_q.size(), 0);
    endtask

    task automatic idle_cycles(input int n);
        bus.ready = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = '0;
        rf_mem[1] = 32'd14;
        rf_mem[2] = 32'd13;
        bus.ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_value("reset_valid", bus.valid, 0);
        check_value("reset_busy", busy, 0);
        check_value("reset_done", done, 0);
        check_value("reset_rf_addr", rf_addr, 0);
        check_value("reset_data", bus.data, 0);
        check_value("reset_index", bus.index, 0);
        check_value("reset_last", bus.last, 0);
        check_value("reset_is_csum", bus.is_csum, 0);
        reset_n = 1'b1;
        idle_cycles(2);

        run_dump(0);            // basic dump
        idle_cycles(3);
        run_dump(1);            // random backpressure plus long stall at x5
        idle_cycles(3);
        run_dump(2);            // start ignored while busy
        run_dump(0);            // start in the done cycle: back-to-back
        idle_cycles(3);
        run_dump(3);            // reset mid-dump
        idle_cycles(2);
        run_dump(0);            // restarts from x0
        idle_cycles(3);
        run_dump(4);            // concurrent write of x20
        idle_cycles(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
